// File: rtl/sim_ctrl_pkg.sv
// Shared encodings for the CPU run/termination controller.
// No logic; state, status codes and default counter width only.
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE    = 2'd0,
    ST_HALT    = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_LOOP    = 2'd3
  } status_t;

  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency 1 cycle; no backpressure, holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sim_run_controller.sv
// Core run controller: reset sequencing, cycle/instret counting, halt/timeout/loop stop.
// All outputs registered (1 cycle); no backpressure. RUN_CTRL_LOOP_DETECT_EN adds PC self-loop stop.
module sim_run_controller
  import sim_ctrl_pkg::*;
#(
  parameter int          CNT_W        = CNT_W_DEF,
  parameter int          PC_W         = 32,
  parameter int          RESET_CYCLES = 4,
  parameter int unsigned MAX_CLOCKS   = 100000,
  parameter int          LOOP_LIMIT   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             retire,
  input  logic             halt_req,
  output logic             cpu_rst_n,
  output logic             running,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycles_consumed,
  output logic [CNT_W-1:0] instret
);

  localparam int CW1 = CNT_W + 1;
  localparam logic [CW1-1:0] MAX_C = CW1'(MAX_CLOCKS);

  state_t     state, state_nxt;
  status_t    status_q, status_nxt;
  logic [7:0] hold_cnt;
  logic       launch;
  logic       timeout_hit;
  logic       loop_hit;

  // cycles_consumed still holds the count of earlier RUN cycles, so +1 names this one
  assign timeout_hit = (MAX_CLOCKS != 0) &&
                       (({1'b0, cycles_consumed} + CW1'(1)) == MAX_C);

`ifdef RUN_CTRL_LOOP_DETECT_EN
  localparam int LW = $clog2(LOOP_LIMIT + 1);

  logic [PC_W-1:0] last_pc;
  logic [LW-1:0]   loop_cnt;
  logic            pc_same;

  assign pc_same  = (pc == last_pc);
  assign loop_hit = (state == RUN) && pc_same && (loop_cnt == LW'(LOOP_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pc  <= '0;
      loop_cnt <= '0;
    end else if (launch) begin
      last_pc  <= '0;
      loop_cnt <= '0;
    end else if (state == RUN) begin
      last_pc <= pc;
      if (!pc_same)
        loop_cnt <= '0;
      else if (loop_cnt != LW'(LOOP_LIMIT))
        loop_cnt <= loop_cnt + LW'(1);
    end
  end
`else
  logic unused_loop;
  assign unused_loop = (^pc) ^ (LOOP_LIMIT != 0);
  assign loop_hit    = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    status_nxt = status_q;
    launch     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt  = HOLD;
          status_nxt = ST_NONE;
          launch     = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt == 8'(RESET_CYCLES - 1))
          state_nxt = RUN;
      end
      RUN: begin
        if (halt_req) begin
          state_nxt  = DONE;
          status_nxt = ST_HALT;
        end else if (timeout_hit) begin
          state_nxt  = DONE;
          status_nxt = ST_TIMEOUT;
        end else if (loop_hit) begin
          state_nxt  = DONE;
          status_nxt = ST_LOOP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      status_q  <= ST_NONE;
      hold_cnt  <= '0;
      cpu_rst_n <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      status_q  <= status_nxt;
      cpu_rst_n <= (state_nxt == RUN);
      running   <= (state_nxt == RUN);
      done      <= (state_nxt == DONE);
      if (launch)
        hold_cnt <= '0;
      else if (state == HOLD)
        hold_cnt <= hold_cnt + 8'd1;
    end
  end

  assign status = status_q;

  sat_counter #(.W(CNT_W)) u_cycles (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .inc (state == RUN),
    .cnt (cycles_consumed)
  );

  sat_counter #(.W(CNT_W)) u_instret (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .inc ((state == RUN) && retire),
    .cnt (instret)
  );

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench: main controller (MAX_CLOCKS=50) plus a 4-bit-counter instance for saturation.
module tb_sim_run_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_s = 1'b0;
  logic [31:0] pc = '0;
  logic        retire = 1'b0;
  logic        halt_req = 1'b0;

  logic        cpu_rst_n_m, running_m, done_m;
  logic [1:0]  status_m;
  logic [31:0] cycles_m, instret_m;

  logic        cpu_rst_n_s, running_s, done_s;
  logic [1:0]  status_s;
  logic [3:0]  cycles_s, instret_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sim_run_controller #(
    .CNT_W(32), .PC_W(32), .RESET_CYCLES(4), .MAX_CLOCKS(50), .LOOP_LIMIT(8)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .retire(retire), .halt_req(halt_req),
    .cpu_rst_n(cpu_rst_n_m), .running(running_m), .done(done_m), .status(status_m),
    .cycles_consumed(cycles_m), .instret(instret_m)
  );

  sim_run_controller #(
    .CNT_W(4), .PC_W(32), .RESET_CYCLES(4), .MAX_CLOCKS(0), .LOOP_LIMIT(8)
  ) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .pc(pc), .retire(retire), .halt_req(halt_req),
    .cpu_rst_n(cpu_rst_n_s), .running(running_s), .done(done_s), .status(status_s),
    .cycles_consumed(cycles_s), .instret(instret_s)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulses start, then waits (bounded) for RUN; returns at the negedge of run cycle 1.
  task automatic launch(input bit sat);
    if (sat) start_s = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_s = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (sat ? running_s : running_m) break;
      @(negedge clk);
    end
    check_eq("launch_running", sat ? running_s : running_m, 1);
  endtask

  // retire_mode: 0 none, 1 odd run cycles, 2 every cycle. loop_pc: pc parks at 0x40 from run cycle 4.
  task automatic drive_run(input bit sat, input int max_cyc, input int halt_at,
                           input int retire_mode, input bit loop_pc);
    for (int r = 1; r <= max_cyc; r++) begin
      if (sat ? done_s : done_m) break;
      retire   = (retire_mode == 2) || (retire_mode == 1 && (r % 2) == 1);
      halt_req = (r == halt_at);
      pc       = (loop_pc && r >= 4) ? 32'h40 : 32'(r * 4);
      @(negedge clk);
    end
    retire   = 1'b0;
    halt_req = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_cpu_rst_n", cpu_rst_n_m, 0);
    check_eq("rst_running", running_m, 0);
    check_eq("rst_done", done_m, 0);
    check_eq("rst_status", status_m, 0);
    check_eq("rst_cycles", cycles_m, 0);
    check_eq("rst_instret", instret_m, 0);
    check_eq("rst_sat_cycles", cycles_s, 0);
    rst = 1'b0;
    repeat (9) @(negedge clk);

    // Reset hold: four low cycles after the start edge, then RUN.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check_eq("hold_cpu_rst_n", cpu_rst_n_m, 0);
      check_eq("hold_running", running_m, 0);
      @(negedge clk);
    end
    check_eq("run_cpu_rst_n", cpu_rst_n_m, 1);
    check_eq("run_running", running_m, 1);

    // Halt on run cycle 20, retire on odd cycles, stray start on cycle 5.
    for (int r = 1; r <= 20; r++) begin
      if (r == 2) begin
        check_eq("lag_cycles", cycles_m, 1);
        check_eq("lag_instret", instret_m, 1);
      end
      retire   = (r % 2) == 1;
      halt_req = (r == 20);
      start    = (r == 5);
      pc       = 32'(r * 4);
      @(negedge clk);
    end
    retire = 1'b0; halt_req = 1'b0; start = 1'b0;
    check_eq("halt_done", done_m, 1);
    check_eq("halt_running", running_m, 0);
    check_eq("halt_status", status_m, 1);
    check_eq("halt_cycles", cycles_m, 20);
    check_eq("halt_instret", instret_m, 10);
    check_eq("halt_cpu_rst_n", cpu_rst_n_m, 0);
    retire = 1'b1; halt_req = 1'b1;
    @(negedge clk);
    retire = 1'b0; halt_req = 1'b0;
    check_eq("done_hold_instret", instret_m, 10);
    check_eq("done_hold_status", status_m, 1);

    // Budget exhausted.
    launch(0);
    check_eq("restart_cycles", cycles_m, 0);
    check_eq("restart_status", status_m, 0);
    drive_run(0, 60, 0, 0, 0);
    check_eq("tmo_done", done_m, 1);
    check_eq("tmo_status", status_m, 2);
    check_eq("tmo_cycles", cycles_m, 50);

    // Halt on the final budget cycle beats timeout.
    launch(0);
    drive_run(0, 60, 50, 1, 0);
    check_eq("halt50_status", status_m, 1);
    check_eq("halt50_cycles", cycles_m, 50);
    check_eq("halt50_instret", instret_m, 25);

    // PC parked at 0x40 from run cycle 4: unchanged on cycles 5..12.
    launch(0);
    drive_run(0, 60, 0, 0, 1);
    check_eq("loop_done", done_m, 1);
`ifdef RUN_CTRL_LOOP_DETECT_EN
    check_eq("loop_status", status_m, 3);
    check_eq("loop_cycles", cycles_m, 12);
`else
    check_eq("loop_status", status_m, 2);
    check_eq("loop_cycles", cycles_m, 50);
`endif

    // Reset in the middle of a run.
    launch(0);
    drive_run(0, 6, 0, 2, 0);
    check_eq("pre_rst_cycles", cycles_m, 6);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_cpu_rst_n", cpu_rst_n_m, 0);
    check_eq("midrst_running", running_m, 0);
    check_eq("midrst_done", done_m, 0);
    check_eq("midrst_status", status_m, 0);
    check_eq("midrst_cycles", cycles_m, 0);
    check_eq("midrst_instret", instret_m, 0);
    rst = 1'b0;
    @(negedge clk);
    launch(0);
    check_eq("clean_cycles0", cycles_m, 0);
    drive_run(0, 60, 3, 2, 0);
    check_eq("clean_status", status_m, 1);
    check_eq("clean_cycles", cycles_m, 3);
    check_eq("clean_instret", instret_m, 3);

    // 4-bit counters saturate at 15.
    launch(1);
    drive_run(1, 30, 20, 2, 0);
    check_eq("sat_done", done_s, 1);
    check_eq("sat_status", status_s, 1);
    check_eq("sat_instret", instret_s, 15);
    check_eq("sat_cycles", cycles_s, 15);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    check_eq("sat_restart_cycles", cycles_s, 0);
    check_eq("sat_restart_instret", instret_s, 0);
    check_eq("sat_restart_status", status_s, 0);
    check_eq("sat_restart_done", done_s, 0);
    check_eq("sat_restart_cpu_rst_n", cpu_rst_n_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
